// File: rtl/ram_arbiter.sv
// Shares one single-port, asynchronous-read data RAM between CHANNELS masters.
// Each granted access runs a fixed IDLE -> ACCESS -> RESPOND transaction.
module ram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int RAMDEPTH  = 2048,
    parameter bit FIXEDPRIO = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS-1:0]       we,
    input  logic [CHANNELS*WIDTH-1:0] addr,
    input  logic [CHANNELS*WIDTH-1:0] wdata,
    output logic [CHANNELS-1:0]       ack,
    output logic                      err,
    output logic [WIDTH-1:0]          rdata,
    output logic [WIDTH-1:0]          ramaddress,
    output logic [WIDTH-1:0]          writeramdata,
    output logic                      writeram,
    input  logic [WIDTH-1:0]          readramdata,
    output logic [1:0]                fsm_state
);
    // Handshake: a master raises req[i] with stable we/addr/wdata and holds it
    // until ack[i] pulses for one cycle; req still high after ack is a new request.

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(4 * RAMDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]    last_grant, grant_idx, win_idx, cand;
    logic             found;
    int               cand_i;
    logic [WIDTH-1:0] sel_addr, sel_wdata;
    logic             sel_we, lat_we, in_range;

    assign fsm_state = state;
    // ramaddress is the latched access address, so the range check reads it directly.
    assign in_range = ({1'b0, ramaddress} < LIMIT);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = ACCESS;
            ACCESS:  state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        writeram = 1'b0;
        ack      = '0;
        err      = 1'b0;
        case (state)
            ACCESS:  writeram = lat_we & in_range;
            RESPOND: begin
                ack[win_idx] = 1'b1;
                err          = ~in_range;
            end
            default: ;
        endcase
    end

    // Round-robin starts after the last grant; fixed priority always starts at 0.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand_i    = 0;
        cand      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (FIXEDPRIO) cand_i = i;
            else           cand_i = (int'(last_grant) + 1 + i) % CHANNELS;
            cand = IW'(cand_i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_addr  = addr[i*WIDTH +: WIDTH];
                sel_wdata = wdata[i*WIDTH +: WIDTH];
                sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_idx      <= '0;
            last_grant   <= IW'(CHANNELS - 1);
            lat_we       <= 1'b0;
            ramaddress   <= '0;
            writeramdata <= '0;
            rdata        <= '0;
        end else begin
            if (state == IDLE && |req) begin
                win_idx      <= grant_idx;
                lat_we       <= sel_we;
                ramaddress   <= sel_addr;
                writeramdata <= sel_wdata;
                if (!FIXEDPRIO) last_grant <= grant_idx;
            end
            if (state == ACCESS)
                rdata <= (!lat_we && in_range) ? readramdata : '0;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized checks of ram_arbiter: a round-robin and a fixed-priority
// instance share master inputs, each backed by its own behavioural RAM.
module tb_ram_arbiter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0, we = '0;
    logic [127:0] addr = '0, wdata = '0;

    logic [3:0]  rr_ack, fp_ack;
    logic        rr_err, fp_err, rr_writeram, fp_writeram;
    logic [31:0] rr_rdata, fp_rdata, rr_ramaddress, fp_ramaddress;
    logic [31:0] rr_writeramdata, fp_writeramdata, rr_rd, fp_rd;
    logic [1:0]  rr_state, fp_state;

    logic [31:0] rr_mem [0:2047];
    logic [31:0] fp_mem [0:2047];

    ram_arbiter #(.WIDTH(32), .CHANNELS(4), .RAMDEPTH(2048), .FIXEDPRIO(1'b0)) u_rr (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(rr_ack), .err(rr_err), .rdata(rr_rdata), .ramaddress(rr_ramaddress),
        .writeramdata(rr_writeramdata), .writeram(rr_writeram), .readramdata(rr_rd),
        .fsm_state(rr_state));

    ram_arbiter #(.WIDTH(32), .CHANNELS(4), .RAMDEPTH(2048), .FIXEDPRIO(1'b1)) u_fp (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(fp_ack), .err(fp_err), .rdata(fp_rdata), .ramaddress(fp_ramaddress),
        .writeramdata(fp_writeramdata), .writeram(fp_writeram), .readramdata(fp_rd),
        .fsm_state(fp_state));

    always #5 clock = ~clock;

    // Asynchronous-read RAMs; out-of-range addresses return a non-zero pattern.
    assign rr_rd = (rr_ramaddress < 32'h2000) ? rr_mem[rr_ramaddress[12:2]] : 32'hA5A5A5A5;
    assign fp_rd = (fp_ramaddress < 32'h2000) ? fp_mem[fp_ramaddress[12:2]] : 32'hA5A5A5A5;

    always @(posedge clock) begin
        if (rr_writeram) rr_mem[rr_ramaddress[12:2]] <= rr_writeramdata;
        if (fp_writeram) fp_mem[fp_ramaddress[12:2]] <= fp_writeramdata;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit          pend_v [4];
    bit          pend_we [4];
    logic [31:0] pend_addr [4];
    logic [31:0] pend_wdata [4];
    logic [31:0] ref_mem [int];
    int          rr_last = 3;
    int          ack_cnt [4];
    int          fp_cnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int k = int'(a >> 2);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic set_op(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
        pend_v[c] = 1'b1; pend_we[c] = w; pend_addr[c] = a; pend_wdata[c] = d;
    endtask

    task automatic rand_op(input int c);
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) != 0) ? 32'h2000 + 32'($urandom_range(0, 255)) * 4 : 32'hFFFFFFFC;
        else
            a = 32'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(2032, 2047)) * 4
                + 32'($urandom_range(0, 3));
        set_op(c, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic clear_ops();
        for (int c = 0; c < 4; c++) pend_v[c] = 1'b0;
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            req[c] = pend_v[c];
            we[c]  = pend_we[c];
            addr[c*32 +: 32]  = pend_addr[c];
            wdata[c*32 +: 32] = pend_wdata[c];
        end
    endtask

    task automatic pulse_reset();
        clear_ops();
        drive();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rr_last = 3;
    endtask

    // One full transaction from an IDLE negedge; expected winner from the arbitration rules.
    task automatic step(output int w);
        int          wf;
        logic [31:0] a;
        bit          oor;
        drive();
        check("idle_ack", 32'(rr_ack), 0);
        check("idle_writeram", 32'(rr_writeram), 0);
        w = -1;
        for (int k = 1; k <= 4; k++)
            if (w < 0 && pend_v[(rr_last + k) % 4]) w = (rr_last + k) % 4;
        wf = -1;
        for (int k = 0; k < 4; k++)
            if (wf < 0 && pend_v[k]) wf = k;
        a   = pend_addr[w];
        oor = (a >= 32'h2000);
        @(posedge clock);
        @(negedge clock);
        check("acc_ack", 32'(rr_ack), 0);
        check("acc_writeram", 32'(rr_writeram), 32'(pend_we[w] && !oor));
        check("acc_ramaddress", rr_ramaddress, a);
        if (pend_we[w]) check("acc_writeramdata", rr_writeramdata, pend_wdata[w]);
        @(negedge clock);
        check("rsp_ack", 32'(rr_ack), 32'(1) << w);
        check("rsp_err", 32'(rr_err), 32'(oor));
        check("rsp_rdata", rr_rdata, (pend_we[w] || oor) ? 32'h0 : ref_read(a));
        check("rsp_writeram", 32'(rr_writeram), 0);
        check("fp_ack", 32'(fp_ack), 32'(1) << wf);
        if (pend_we[w] && !oor) ref_mem[int'(a >> 2)] = pend_wdata[w];
        rr_last = w;
        ack_cnt[w]++;
        fp_cnt[wf]++;
        @(negedge clock);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 2048; i++) begin
            rr_mem[i] = '0;
            fp_mem[i] = '0;
        end
        clear_ops();
        drive();
        repeat (2) @(negedge clock);
        check("rst_ack", 32'(rr_ack), 0);
        check("rst_err", 32'(rr_err), 0);
        check("rst_rdata", rr_rdata, 0);
        check("rst_ramaddress", rr_ramaddress, 0);
        check("rst_writeramdata", rr_writeramdata, 0);
        check("rst_writeram", 32'(rr_writeram), 0);
        check("rst_fp_ack", 32'(fp_ack), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single write then read on the core channel.
        set_op(0, 1'b1, 32'h10, 32'hDEADBEEF);
        step(w);
        set_op(0, 1'b0, 32'h10, 32'h0);
        step(w);
        check("wr_rd_value", rr_rdata, 32'hDEADBEEF);
        clear_ops();

        // Out-of-range write and read; word 0 (the aliased index) must stay untouched.
        set_op(2, 1'b1, 32'h2000, 32'h12345678);
        step(w);
        set_op(2, 1'b0, 32'h2000, 32'h0);
        step(w);
        clear_ops();
        set_op(0, 1'b0, 32'h0, 32'h0);
        step(w);
        clear_ops();

        // Last word of the RAM.
        set_op(1, 1'b1, 32'h1FFC, 32'hCAFEF00D);
        step(w);
        set_op(1, 1'b0, 32'h1FFC, 32'h0);
        step(w);

        // Reset during the ACCESS cycle of a ch1 read.
        drive();
        @(posedge clock);
        @(negedge clock);
        check("midrst_acc_addr", rr_ramaddress, 32'h1FFC);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_ack", 32'(rr_ack), 0);
        check("midrst_err", 32'(rr_err), 0);
        check("midrst_rdata", rr_rdata, 0);
        check("midrst_ramaddress", rr_ramaddress, 0);
        check("midrst_writeramdata", rr_writeramdata, 0);
        check("midrst_writeram", 32'(rr_writeram), 0);
        check("midrst_fp_ack", 32'(fp_ack), 0);
        reset = 1'b0;
        rr_last = 3;
        step(w);
        clear_ops();

        // Round-robin fairness with all four channels requesting continuously.
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            ack_cnt[c] = 0;
            set_op(c, 1'b0, 32'(c) * 4, 32'h0);
        end
        for (int i = 0; i < 12; i++) begin
            step(w);
            check("rr_order", 32'(w), 32'(i % 4));
            set_op(w, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 4, $urandom);
        end
        for (int c = 0; c < 4; c++) check("rr_ack_count", 32'(ack_cnt[c]), 3);

        // Fixed priority: ch1 starves ch3 until it drops its request.
        pulse_reset();
        for (int c = 0; c < 4; c++) fp_cnt[c] = 0;
        set_op(1, 1'b0, 32'h10, 32'h0);
        set_op(3, 1'b0, 32'h1FFC, 32'h0);
        repeat (4) step(w);
        check("fp_ch1_served", 32'(fp_cnt[1]), 4);
        check("fp_ch3_starved", 32'(fp_cnt[3]), 0);
        pend_v[1] = 1'b0;
        step(w);
        check("fp_ch3_after_drop", 32'(fp_cnt[3]), 1);
        clear_ops();

        // Randomized traffic against the reference rules.
        for (int i = 0; i < 150; i++) begin
            for (int c = 0; c < 4; c++)
                if (!pend_v[c] && $urandom_range(0, 3) == 0) rand_op(c);
            if (!(pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3])) rand_op(int'($urandom_range(0, 3)));
            step(w);
            if ($urandom_range(0, 1) != 0) rand_op(w);
            else pend_v[w] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
